// File: rtl/mmu_req_sequencer.sv
// -----------------------------------------------------------------------------
// mmu_req_sequencer
//
// Translation front-end in front of the load/store MMU port of the address
// generator. Accepts one virtual-address translation at a time. Repeat accesses
// to the same page are answered from a one-entry micro-TLB. Anything else
// raises a single-cycle MMU request and waits, with a timeout, for the result.
// The physical address or exception goes back over a response handshake.
//
// Ports
//   clk_i, rst_ni               clock, synchronous active-low reset
//   en_ld_st_translation_i      translation enable, sampled at acceptance
//   flush_i                     invalidate the micro-TLB entry
//   req_valid_i / req_ready_o   request handshake (ready only in IDLE)
//   req_vaddr_i, req_is_store_i request virtual address and store flag
//   rsp_valid_o / rsp_ready_i   response handshake
//   rsp_paddr_o, rsp_exception_o  response physical address and exception
//   mmu_req_o, mmu_vaddr_o, mmu_is_store_o   one-cycle request to the MMU
//   mmu_valid_i, mmu_paddr_i, mmu_exception_i  MMU result
//   timeout_o                   one-cycle pulse when the MMU wait expires
// -----------------------------------------------------------------------------

// Local mirror of ariane_pkg::exception_t so the block stands alone; field
// order and widths match the core's definition at integration.
package mmu_req_sequencer_pkg;
    localparam int unsigned XLEN = 64;
    localparam logic [XLEN-1:0] LOAD_ACCESS_FAULT  = XLEN'(5);
    localparam logic [XLEN-1:0] STORE_ACCESS_FAULT = XLEN'(7);

    typedef struct packed {
        logic [XLEN-1:0] cause;
        logic [XLEN-1:0] tval;
        logic            valid;
    } exception_t;
endpackage

module mmu_req_sequencer
    import mmu_req_sequencer_pkg::*;
#(
    parameter int unsigned VAddrWidth     = 64,
    parameter int unsigned PAddrWidth     = 56,
    parameter int unsigned PageOffsetBits = 12,
    parameter int unsigned TimeoutCycles  = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  en_ld_st_translation_i,
    input  logic                  flush_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [VAddrWidth-1:0] req_vaddr_i,
    input  logic                  req_is_store_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [PAddrWidth-1:0] rsp_paddr_o,
    output exception_t            rsp_exception_o,
    output logic                  mmu_req_o,
    output logic [VAddrWidth-1:0] mmu_vaddr_o,
    output logic                  mmu_is_store_o,
    input  logic                  mmu_valid_i,
    input  logic [PAddrWidth-1:0] mmu_paddr_i,
    input  exception_t            mmu_exception_i,
    output logic                  timeout_o
);

    localparam int unsigned VpnW = VAddrWidth - PageOffsetBits;
    localparam int unsigned PpnW = PAddrWidth - PageOffsetBits;
    localparam int unsigned CntW = $clog2(TimeoutCycles + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RSP} state_e;

    state_e                r_state, w_state_next;
    logic [VAddrWidth-1:0] r_vaddr;
    logic                  r_is_store;
    logic                  r_en;
    logic [PAddrWidth-1:0] r_paddr;
    exception_t            r_exc;
    logic                  r_tlb_valid;
    logic [VpnW-1:0]       r_tlb_vpn;
    logic [PpnW-1:0]       r_tlb_ppn;
    logic                  r_tlb_store_ok;
    logic [CntW-1:0]       r_cnt;

    logic w_accept, w_hit, w_mmu_done, w_expire, w_fill;

    assign w_accept = rst_ni && (r_state == IDLE) && req_valid_i;

    // Lookup reads the registered entry, so a flush in the acceptance cycle
    // only takes effect for later requests. A load-filled entry does not
    // grant store permission.
    assign w_hit = r_tlb_valid
                && (r_tlb_vpn == req_vaddr_i[VAddrWidth-1:PageOffsetBits])
                && (r_tlb_store_ok || !req_is_store_i);

    assign w_mmu_done = (r_state == WAIT) && mmu_valid_i;
    // A result arriving in the expiry cycle takes priority over the timeout.
    assign w_expire   = (r_state == WAIT) && !mmu_valid_i
                     && (r_cnt == CntW'(TimeoutCycles - 1));
    // Faulting translations are never cached; a concurrent flush wins.
    assign w_fill     = w_mmu_done && r_en && !mmu_exception_i.valid && !flush_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // All outputs are forced low while reset is asserted, including ready.
    always_comb begin
        w_state_next    = r_state;
        req_ready_o     = 1'b0;
        rsp_valid_o     = 1'b0;
        rsp_paddr_o     = '0;
        rsp_exception_o = '0;
        mmu_req_o       = 1'b0;
        mmu_vaddr_o     = '0;
        mmu_is_store_o  = 1'b0;
        timeout_o       = 1'b0;
        if (rst_ni) begin
            unique case (r_state)
                IDLE: begin
                    req_ready_o = 1'b1;
                    if (req_valid_i) begin
                        w_state_next = (!en_ld_st_translation_i || w_hit) ? RSP : REQ;
                    end
                end
                REQ: begin
                    mmu_req_o      = 1'b1;
                    mmu_vaddr_o    = r_vaddr;
                    mmu_is_store_o = r_is_store;
                    w_state_next   = WAIT;
                end
                WAIT: begin
                    mmu_vaddr_o    = r_vaddr;
                    mmu_is_store_o = r_is_store;
                    timeout_o      = w_expire;
                    if (mmu_valid_i || w_expire) begin
                        w_state_next = RSP;
                    end
                end
                RSP: begin
                    rsp_valid_o     = 1'b1;
                    rsp_paddr_o     = r_paddr;
                    rsp_exception_o = r_exc;
                    if (rsp_ready_i) begin
                        w_state_next = IDLE;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_vaddr        <= '0;
            r_is_store     <= 1'b0;
            r_en           <= 1'b0;
            r_paddr        <= '0;
            r_exc          <= '0;
            r_tlb_valid    <= 1'b0;
            r_tlb_vpn      <= '0;
            r_tlb_ppn      <= '0;
            r_tlb_store_ok <= 1'b0;
            r_cnt          <= '0;
        end else begin
            if (w_accept) begin
                r_vaddr    <= req_vaddr_i;
                r_is_store <= req_is_store_i;
                r_en       <= en_ld_st_translation_i;
                r_exc      <= '0;
                // With translation off the micro-TLB is bypassed entirely.
                if (!en_ld_st_translation_i) begin
                    r_paddr <= req_vaddr_i[PAddrWidth-1:0];
                end else if (w_hit) begin
                    r_paddr <= {r_tlb_ppn, req_vaddr_i[PageOffsetBits-1:0]};
                end
            end

            if (r_state == REQ) begin
                r_cnt <= '0;
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt + CntW'(1);
            end

            if (w_mmu_done) begin
                r_paddr <= mmu_paddr_i;
                r_exc   <= mmu_exception_i;
            end else if (w_expire) begin
                // No translation exists on timeout; report an access fault
                // with a zero physical address.
                r_paddr     <= '0;
                r_exc.valid <= 1'b1;
                r_exc.cause <= r_is_store ? STORE_ACCESS_FAULT : LOAD_ACCESS_FAULT;
                r_exc.tval  <= XLEN'(r_vaddr);
            end

            if (flush_i) begin
                r_tlb_valid <= 1'b0;
            end else if (w_fill) begin
                r_tlb_valid    <= 1'b1;
                r_tlb_vpn      <= r_vaddr[VAddrWidth-1:PageOffsetBits];
                r_tlb_ppn      <= mmu_paddr_i[PAddrWidth-1:PageOffsetBits];
                r_tlb_store_ok <= r_is_store;
            end
        end
    end

endmodule

// File: tb/tb_mmu_req_sequencer.sv
module tb_mmu_req_sequencer;
    import mmu_req_sequencer_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_ni;
    logic        en_ld_st_translation_i;
    logic        flush_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [63:0] req_vaddr_i;
    logic        req_is_store_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [55:0] rsp_paddr_o;
    exception_t  rsp_exception_o;
    logic        mmu_req_o;
    logic [63:0] mmu_vaddr_o;
    logic        mmu_is_store_o;
    logic        mmu_valid_i;
    logic [55:0] mmu_paddr_i;
    exception_t  mmu_exception_i;
    logic        timeout_o;

    mmu_req_sequencer #(
        .VAddrWidth(64), .PAddrWidth(56), .PageOffsetBits(12), .TimeoutCycles(4)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .en_ld_st_translation_i(en_ld_st_translation_i), .flush_i(flush_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_vaddr_i(req_vaddr_i), .req_is_store_i(req_is_store_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_paddr_o(rsp_paddr_o), .rsp_exception_o(rsp_exception_o),
        .mmu_req_o(mmu_req_o), .mmu_vaddr_o(mmu_vaddr_o), .mmu_is_store_o(mmu_is_store_o),
        .mmu_valid_i(mmu_valid_i), .mmu_paddr_i(mmu_paddr_i),
        .mmu_exception_i(mmu_exception_i), .timeout_o(timeout_o)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        en;
        logic        st;
        logic [63:0] vaddr;
        int          flush_mode;   // 0 none, 1 cycle before, 2 with accept, 3 with MMU result
        int          mmu_lat;      // cycles after mmu_req_o; <=0 means MMU never answers
        logic [55:0] mmu_paddr;
        logic        mmu_exc;
        logic [63:0] mmu_cause;
        logic [63:0] mmu_tval;
        int          exp_lat;
        logic [55:0] exp_paddr;
        logic        exp_exc;
        logic [63:0] exp_cause;
        logic [63:0] exp_tval;
        int          exp_reqs;
        int          exp_to;
    } vec_t;

    typedef struct {
        int          lat;
        logic [55:0] paddr;
        exception_t  exc;
        bit          skip_paddr;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[20];

    function automatic vec_t V(logic en, logic st, logic [63:0] vaddr, int fm, int lat,
                               logic [55:0] mpa, logic mexc, logic [63:0] mcause, logic [63:0] mtval,
                               int elat, logic [55:0] epa, logic eexc, logic [63:0] ecause,
                               logic [63:0] etval, int ereqs, int eto);
        vec_t v;
        v.en = en; v.st = st; v.vaddr = vaddr; v.flush_mode = fm; v.mmu_lat = lat;
        v.mmu_paddr = mpa; v.mmu_exc = mexc; v.mmu_cause = mcause; v.mmu_tval = mtval;
        v.exp_lat = elat; v.exp_paddr = epa; v.exp_exc = eexc; v.exp_cause = ecause;
        v.exp_tval = etval; v.exp_reqs = ereqs; v.exp_to = eto;
        return v;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] all_outs();
        return 256'({req_ready_o, rsp_valid_o, rsp_paddr_o, rsp_exception_o, mmu_req_o,
                      mmu_vaddr_o, mmu_is_store_o, timeout_o});
    endfunction

    // One full transaction: drive the request, model the MMU, consume the response.
    task automatic run_txn(input string tag, input vec_t v);
        exp_t e;
        exp_t got;
        int   t_req;
        int   nreq;
        int   nto;
        bit   done;
        e.lat = v.exp_lat;
        e.paddr = v.exp_paddr;
        e.exc.valid = v.exp_exc;
        e.exc.cause = v.exp_cause;
        e.exc.tval = v.exp_tval;
        e.skip_paddr = (v.exp_to > 0);
        sb.push_back(e);
        if (v.flush_mode == 1) begin
            @(negedge clk);
            req_valid_i = 1'b0; mmu_valid_i = 1'b0; flush_i = 1'b1;
        end
        t_req = -1; nreq = 0; nto = 0; done = 1'b0;
        for (int t = 0; t < 40 && !done; t++) begin
            @(negedge clk);
            req_valid_i = (t == 0);
            req_vaddr_i = v.vaddr;
            req_is_store_i = v.st;
            en_ld_st_translation_i = v.en;
            rsp_ready_i = 1'b1;
            mmu_valid_i = (v.mmu_lat > 0) && (t_req >= 0) && (t == t_req + v.mmu_lat);
            mmu_paddr_i = v.mmu_paddr;
            mmu_exception_i.valid = v.mmu_exc;
            mmu_exception_i.cause = v.mmu_cause;
            mmu_exception_i.tval = v.mmu_tval;
            flush_i = ((v.flush_mode == 2) && (t == 0)) || ((v.flush_mode == 3) && mmu_valid_i);
            #1;
            if (t == 0) chk({tag, ".accept"}, 256'(req_ready_o), 256'(1));
            if (mmu_req_o) begin
                nreq++;
                if (t_req < 0) begin
                    t_req = t;
                    chk({tag, ".mmu_vaddr"}, 256'(mmu_vaddr_o), 256'(v.vaddr));
                    chk({tag, ".mmu_is_store"}, 256'(mmu_is_store_o), 256'(v.st));
                end
            end
            if (timeout_o) nto++;
            if (rsp_valid_o) begin
                done = 1'b1;
                if (sb.size() == 0) begin
                    chk({tag, ".unexpected_rsp"}, 256'(1), 256'(0));
                end else begin
                    got = sb.pop_front();
                    chk({tag, ".latency"}, 256'(t), 256'(got.lat));
                    if (!got.skip_paddr) chk({tag, ".paddr"}, 256'(rsp_paddr_o), 256'(got.paddr));
                    chk({tag, ".exception"}, 256'(rsp_exception_o), 256'(got.exc));
                end
            end
        end
        @(negedge clk);
        flush_i = 1'b0; mmu_valid_i = 1'b0; req_valid_i = 1'b0;
        if (!done) begin
            chk({tag, ".rsp_wait_budget"}, 256'(0), 256'(1));
            void'(sb.pop_front());
        end
        chk({tag, ".mmu_req_count"}, 256'(nreq), 256'(v.exp_reqs));
        chk({tag, ".timeout_count"}, 256'(nto), 256'(v.exp_to));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Expected values derived from the page mappings the MMU model returns.
        tbl[0]  = V(0, 0, 64'h0000_0040_1234_5678, 0, -1, 56'h0, 0, 0, 0, 1, 56'h40_1234_5678, 0, 0, 0, 0, 0);
        tbl[1]  = V(1, 0, 64'h1000_3ABC, 0, 1, 56'h8000_3ABC, 0, 0, 0, 3, 56'h8000_3ABC, 0, 0, 0, 1, 0);
        tbl[2]  = V(1, 0, 64'h1000_3FF0, 0, -1, 56'h0, 0, 0, 0, 1, 56'h8000_3FF0, 0, 0, 0, 0, 0);
        tbl[3]  = V(1, 1, 64'h1000_3010, 0, 2, 56'h8000_3010, 0, 0, 0, 4, 56'h8000_3010, 0, 0, 0, 1, 0);
        tbl[4]  = V(1, 1, 64'h1000_3020, 0, -1, 56'h0, 0, 0, 0, 1, 56'h8000_3020, 0, 0, 0, 0, 0);
        tbl[5]  = V(1, 0, 64'h1000_3030, 1, 1, 56'h9000_3030, 0, 0, 0, 3, 56'h9000_3030, 0, 0, 0, 1, 0);
        tbl[6]  = V(1, 0, 64'h1000_3040, 0, -1, 56'h0, 0, 0, 0, 1, 56'h9000_3040, 0, 0, 0, 0, 0);
        tbl[7]  = V(1, 1, 64'h2000_0008, 0, 1, 56'h1234_5000, 1, 64'd15, 64'h2000_0008, 3, 56'h1234_5000, 1, 64'd15, 64'h2000_0008, 1, 0);
        tbl[8]  = V(1, 1, 64'h2000_0008, 0, 1, 56'h7000_0008, 0, 0, 0, 3, 56'h7000_0008, 0, 0, 0, 1, 0);
        tbl[9]  = V(0, 0, 64'h2000_0010, 0, -1, 56'h0, 0, 0, 0, 1, 56'h2000_0010, 0, 0, 0, 0, 0);
        tbl[10] = V(0, 0, 64'h6000_0000, 0, -1, 56'h0, 0, 0, 0, 1, 56'h6000_0000, 0, 0, 0, 0, 0);
        tbl[11] = V(1, 0, 64'h6000_0010, 0, 1, 56'hB000_0010, 0, 0, 0, 3, 56'hB000_0010, 0, 0, 0, 1, 0);
        tbl[12] = V(1, 0, 64'h5555_0123, 0, -1, 56'h0, 0, 0, 0, 6, 56'h0, 1, 64'd5, 64'h5555_0123, 1, 1);
        tbl[13] = V(1, 1, 64'h6666_0040, 0, -1, 56'h0, 0, 0, 0, 6, 56'h0, 1, 64'd7, 64'h6666_0040, 1, 1);
        tbl[14] = V(1, 0, 64'h7777_0100, 0, 4, 56'hC777_0100, 0, 0, 0, 6, 56'hC777_0100, 0, 0, 0, 1, 0);
        tbl[15] = V(1, 0, 64'h7777_0200, 0, -1, 56'h0, 0, 0, 0, 1, 56'hC777_0200, 0, 0, 0, 0, 0);
        tbl[16] = V(1, 0, 64'h3000_0100, 3, 1, 56'hA000_0100, 0, 0, 0, 3, 56'hA000_0100, 0, 0, 0, 1, 0);
        tbl[17] = V(1, 0, 64'h3000_0200, 0, 1, 56'hA000_0200, 0, 0, 0, 3, 56'hA000_0200, 0, 0, 0, 1, 0);
        tbl[18] = V(1, 0, 64'h3000_0300, 2, -1, 56'h0, 0, 0, 0, 1, 56'hA000_0300, 0, 0, 0, 0, 0);
        tbl[19] = V(1, 0, 64'h3000_0400, 0, 1, 56'hA000_0400, 0, 0, 0, 3, 56'hA000_0400, 0, 0, 0, 1, 0);

        rst_ni = 1'b0;
        en_ld_st_translation_i = 1'b0; flush_i = 1'b0;
        req_valid_i = 1'b0; req_vaddr_i = '0; req_is_store_i = 1'b0;
        rsp_ready_i = 1'b0; mmu_valid_i = 1'b0; mmu_paddr_i = '0; mmu_exception_i = '0;

        repeat (3) @(negedge clk);
        #1 chk("reset.outputs_zero", all_outs(), 256'(0));
        @(negedge clk);
        rst_ni = 1'b1;
        #1 chk("reset.ready_after_release", 256'(req_ready_o), 256'(1));
        chk("reset.no_rsp", 256'(rsp_valid_o), 256'(0));

        for (int i = 0; i < 20; i++) begin
            run_txn($sformatf("vec%0d", i), tbl[i]);
        end

        // Late MMU result after a timeout must be ignored.
        run_txn("late.timeout", V(1, 0, 64'h4444_0010, 0, -1, 56'h0, 0, 0, 0, 6, 56'h0, 1, 64'd5, 64'h4444_0010, 1, 1));
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            mmu_valid_i = 1'b1; mmu_paddr_i = 56'h8888_0010; mmu_exception_i = '0;
            #1 chk("late.no_rsp", 256'(rsp_valid_o), 256'(0));
            chk("late.idle", 256'(req_ready_o), 256'(1));
        end
        @(negedge clk);
        mmu_valid_i = 1'b0;
        run_txn("late.not_cached", V(1, 0, 64'h4444_0020, 0, 1, 56'hD444_0020, 0, 0, 0, 3, 56'hD444_0020, 0, 0, 0, 1, 0));

        // Backpressure on a hit, with a stray MMU result during RSP.
        @(negedge clk);
        req_valid_i = 1'b1; req_vaddr_i = 64'h4444_0030; req_is_store_i = 1'b0;
        en_ld_st_translation_i = 1'b1; rsp_ready_i = 1'b0;
        #1 chk("bp.accept", 256'(req_ready_o), 256'(1));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req_valid_i = 1'b0;
            mmu_valid_i = (i == 2); mmu_paddr_i = 56'hFF_FFFF_FFFF;
            #1 chk("bp.rsp_valid", 256'(rsp_valid_o), 256'(1));
            chk("bp.paddr_stable", 256'(rsp_paddr_o), 256'(56'hD444_0030));
            chk("bp.exc_stable", 256'(rsp_exception_o), 256'(0));
            chk("bp.not_ready", 256'(req_ready_o), 256'(0));
        end
        @(negedge clk);
        mmu_valid_i = 1'b0; rsp_ready_i = 1'b1;
        #1 chk("bp.consume_valid", 256'(rsp_valid_o), 256'(1));
        chk("bp.consume_paddr", 256'(rsp_paddr_o), 256'(56'hD444_0030));
        @(negedge clk);
        #1 chk("bp.ready_after", 256'(req_ready_o), 256'(1));
        chk("bp.rsp_dropped", 256'(rsp_valid_o), 256'(0));

        // Reset while waiting on the MMU.
        @(negedge clk);
        req_valid_i = 1'b1; req_vaddr_i = 64'h4545_0000; req_is_store_i = 1'b0;
        @(negedge clk);
        req_valid_i = 1'b0;
        #1 chk("rstw.mmu_req", 256'(mmu_req_o), 256'(1));
        @(negedge clk);
        rst_ni = 1'b0;
        #1 chk("rstw.outputs_zero", all_outs(), 256'(0));
        @(negedge clk);
        #1 chk("rstw.outputs_zero_held", all_outs(), 256'(0));
        @(negedge clk);
        rst_ni = 1'b1;
        #1 chk("rstw.ready", 256'(req_ready_o), 256'(1));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 chk("rstw.quiet", 256'({mmu_req_o, rsp_valid_o}), 256'(0));
        end
        run_txn("rstw.entry_invalid", V(1, 0, 64'h3000_0500, 0, 1, 56'hE000_0500, 0, 0, 0, 3, 56'hE000_0500, 0, 0, 0, 1, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
